// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command sequencer: power-up dummy clocks, 48-bit command
// framing with serial CRC7, R1 polling with timeout and optional R3/R7 payload.
module sd_spi_cmd_engine #(
  parameter int CLK_DIV   = 4,
  parameter int INIT_CLKS = 80,
  parameter int NCR_MAX   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_req,
  output logic        init_done,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_long,
  output logic        rsp_valid,
  output logic [7:0]  rsp_r1,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // state   | meaning
  // IDLE    | waiting for init_req / cmd_valid, SCK parked low
  // INIT    | CS high, MOSI high, INIT_CLKS dummy SCK cycles
  // CMD_TX  | CS low, shifting the 48-bit command frame
  // WAIT_R1 | polling bytes until one has bit7 clear or NCR_MAX expire
  // RSP_RX  | collecting the 4 trailing R3/R7 bytes
  // FINISH  | CS high, 8 trailing SCK cycles, then report the response
  typedef enum logic [2:0] {IDLE, INIT, CMD_TX, WAIT_R1, RSP_RX, FINISH} state_t;

  state_t      state, state_nxt;
  logic        live;
  logic        start;
  logic [7:0]  div;
  logic [7:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [47:0] tx_sh;
  logic [6:0]  crc;
  logic [6:0]  crc_nxt;
  logic        crc_fb;
  logic [6:0]  rx_byte;
  logic [7:0]  rx_nxt;
  logic [31:0] rx_data;
  logic [7:0]  r1_q;
  logic        to_q;
  logic        long_q;
  logic        tick;
  logic        fall;

  // start holds the divider for one cycle so the first SCK rise lands D+1 after entry
  assign tick      = (state != IDLE) && !start && (div == 8'(CLK_DIV - 1));
  assign fall      = tick && spi_sck;
  assign rx_nxt    = {rx_byte, spi_miso};
  assign crc_fb    = tx_sh[47] ^ crc[6];
  assign crc_nxt   = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE) && live;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (live && init_req)       state_nxt = INIT;
        else if (live && cmd_valid) state_nxt = CMD_TX;
      end
      INIT:    if (bit_cnt == 8'(INIT_CLKS)) state_nxt = IDLE;
      CMD_TX:  if (fall && bit_cnt == 8'd47) state_nxt = WAIT_R1;
      WAIT_R1: begin
        if (fall && bit_cnt == 8'd7) begin
          if (!rx_nxt[7])                           state_nxt = long_q ? RSP_RX : FINISH;
          else if (byte_cnt == 8'(NCR_MAX - 1))     state_nxt = FINISH;
        end
      end
      RSP_RX:  if (fall && bit_cnt == 8'd31) state_nxt = FINISH;
      FINISH:  if (bit_cnt == 8'd8) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live        <= 1'b0;
      start       <= 1'b0;
      div         <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      tx_sh       <= '0;
      crc         <= '0;
      rx_byte     <= '0;
      rx_data     <= '0;
      r1_q        <= '0;
      to_q        <= 1'b0;
      long_q      <= 1'b0;
      spi_sck     <= 1'b0;
      spi_cs      <= 1'b1;
      spi_mosi    <= 1'b1;
      init_done   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_r1      <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      live      <= 1'b1;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      start     <= 1'b0;
      if (state == IDLE || tick) div <= '0;
      else if (!start)           div <= div + 8'd1;
      if (tick) spi_sck <= ~spi_sck;
      if (fall) bit_cnt <= bit_cnt + 8'd1;

      case (state)
        IDLE: begin
          spi_sck  <= 1'b0;
          spi_cs   <= 1'b1;
          spi_mosi <= 1'b1;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          if (state_nxt == INIT) begin
            start <= 1'b1;
          end else if (state_nxt == CMD_TX) begin
            start    <= 1'b1;
            spi_cs   <= 1'b0;
            spi_mosi <= 1'b0;
            tx_sh    <= {2'b01, cmd_index, cmd_arg, 8'hFF};
            crc      <= '0;
            long_q   <= cmd_long;
            rx_data  <= '0;
            r1_q     <= 8'hFF;
            to_q     <= 1'b0;
          end
        end
        INIT: if (state_nxt == IDLE) init_done <= 1'b1;
        CMD_TX: begin
          if (fall) begin
            // after bit 39 the frame tail is replaced by the finished CRC and stop bit
            if (bit_cnt == 8'd39) begin
              crc      <= crc_nxt;
              tx_sh    <= {crc_nxt, 1'b1, 40'b0};
              spi_mosi <= crc_nxt[6];
            end else begin
              if (bit_cnt < 8'd39) crc <= crc_nxt;
              tx_sh    <= {tx_sh[46:0], 1'b0};
              spi_mosi <= tx_sh[46];
            end
            if (bit_cnt == 8'd47) begin
              spi_mosi <= 1'b1;
              bit_cnt  <= '0;
            end
          end
        end
        WAIT_R1: begin
          if (fall) begin
            rx_byte <= rx_nxt[6:0];
            if (bit_cnt == 8'd7) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 8'd1;
              if (!rx_nxt[7])                        r1_q <= rx_nxt;
              else if (byte_cnt == 8'(NCR_MAX - 1)) to_q <= 1'b1;
              if (state_nxt == FINISH) spi_cs <= 1'b1;
            end
          end
        end
        RSP_RX: begin
          if (fall) begin
            rx_data <= {rx_data[30:0], spi_miso};
            if (bit_cnt == 8'd31) begin
              bit_cnt <= '0;
              spi_cs  <= 1'b1;
            end
          end
        end
        FINISH: begin
          if (state_nxt == IDLE) begin
            rsp_valid   <= 1'b1;
            rsp_r1      <= r1_q;
            rsp_data    <= rx_data;
            rsp_timeout <= to_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
